serial_sub: RTL

- Parametrised, multi-cycle unsigned subtractor; successor to the single-bit half subtractor.
- Computes diff = a - b - bin over WIDTH bits, consuming BPC bits per clock through a registered borrow chain.
- Valid/ready handshake on both input and output, so it drops into streaming datapaths and trades latency for area.

---
 rtl/serial_sub.sv | 136 +++++++++++++
 1 files changed

// File: rtl/serial_sub.sv
// Multi-cycle unsigned subtractor: diff = a - b - bin, BPC bits per clock through a registered borrow chain.
// Optional macro SERIAL_SUB_SAT_EN clamps an underflowing result to zero (brw still flags the underflow).
module serial_sub #(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             brw
);

  localparam int STEPS = WIDTH / BPC;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_r;
  logic [WIDTH-1:0] diff_r;
  logic             borrow_r;
  logic             brw_r;
  logic [CW-1:0]    cnt_r;

  logic [BPC:0]     slice_s;
  logic [WIDTH-1:0] res_next_s;
  logic [WIDTH-1:0] diff_next_s;
  logic             borrow_next_s;
  logic             accept_s;
  logic             last_s;

  // Slice arithmetic: the extra top bit of the BPC+1-bit difference is the borrow out
  always_comb begin
    accept_s      = in_valid && (state_r == IDLE);
    last_s        = (cnt_r == CW'(STEPS - 1));
    slice_s       = {1'b0, a_r[BPC-1:0]} - {1'b0, b_r[BPC-1:0]} - (BPC+1)'(borrow_r);
    borrow_next_s = slice_s[BPC];
    res_next_s    = (res_r >> BPC) | (WIDTH'(slice_s[BPC-1:0]) << (WIDTH - BPC));
`ifdef SERIAL_SUB_SAT_EN
    if (borrow_next_s) begin
      diff_next_s = {WIDTH{1'b0}};
    end else begin
      diff_next_s = res_next_s;
    end
`else
    diff_next_s = res_next_s;
`endif
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand shifters, borrow chain, step counter and held result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      res_r    <= {WIDTH{1'b0}};
      diff_r   <= {WIDTH{1'b0}};
      borrow_r <= 1'b0;
      brw_r    <= 1'b0;
      cnt_r    <= {CW{1'b0}};
    end else if (accept_s) begin
      a_r      <= a;
      b_r      <= b;
      borrow_r <= bin;
      cnt_r    <= {CW{1'b0}};
    end else if (state_r == RUN) begin
      a_r      <= a_r >> BPC;
      b_r      <= b_r >> BPC;
      res_r    <= res_next_s;
      borrow_r <= borrow_next_s;
      cnt_r    <= cnt_r + CW'(1);
      // diff/brw only change on the final step, so they stay frozen through DONE
      if (last_s) begin
        diff_r <= diff_next_s;
        brw_r  <= borrow_next_s;
      end
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign diff      = diff_r;
  assign brw       = brw_r;

endmodule
